// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, address constants and types for regfile_sb
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

    // x0 is hardwired to zero and never tracked as pending
    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write scoreboard with busy generation per read port
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int NUM_RD = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 flush,
    input  logic [NUM_RD*AW-1:0] raddr,
    output logic [NUM_RD-1:0]    rbusy,
    output logic                 pend_any
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;
    logic [AW-1:0]   rd_addr;

    // Next pending vector: flush beats issue, and a new producer beats a same-cycle writeback
    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end else begin
            if (we) begin
                pending_nxt[waddr] = 1'b0;
            end
            if (issue_valid && issue_rd != AW'(REG_ZERO)) begin
                pending_nxt[issue_rd] = 1'b1;
            end
        end
    end

    // Pending state register, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // A port is busy while its source is pending, unless the writeback lands this cycle
    always_comb begin
        rbusy   = '0;
        rd_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr  = raddr[i*AW +: AW];
            rbusy[i] = pending[rd_addr] && !(we && waddr == rd_addr)
                       && rd_addr != AW'(REG_ZERO);
        end
    end

    assign pend_any = |pending;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with write bypass and pending-write scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NUM_RD = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [XLEN-1:0]        wdata,
    input  logic [NUM_RD*AW-1:0]   raddr,
    output logic [NUM_RD*XLEN-1:0] rdata,
    output logic [NUM_RD-1:0]      rbusy,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_rd,
    input  logic                   flush,
    output logic                   pend_any
);

    logic [XLEN-1:0] regs [NREG];
    logic [AW-1:0]   rd_addr;

    // Register storage: whole array clears on reset, x0 is never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (we && waddr != AW'(REG_ZERO)) begin
            regs[waddr] <= wdata;
        end
    end

    // Combinational read ports: x0 reads zero, a same-cycle write is forwarded
    always_comb begin
        rdata   = '0;
        rd_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr = raddr[i*AW +: AW];
            if (rd_addr == AW'(REG_ZERO)) begin
                rdata[i*XLEN +: XLEN] = '0;
            end else if (we && waddr == rd_addr) begin
                rdata[i*XLEN +: XLEN] = wdata;
            end else begin
                rdata[i*XLEN +: XLEN] = regs[rd_addr];
            end
        end
    end

    regfile_scoreboard #(
        .NREG   (NREG),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .waddr       (waddr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .raddr       (raddr),
        .rbusy       (rbusy),
        .pend_any    (pend_any)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb against a behavioural model
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [XLEN-1:0]      wdata;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic [NRD-1:0]       rbusy;
    logic                 issue_valid;
    logic [AW-1:0]        issue_rd;
    logic                 flush;
    logic                 pend_any;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] mreg  [NREG];
    bit              mpend [NREG];

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NRD)) dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr       (raddr),
        .rdata       (rdata),
        .rbusy       (rbusy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .pend_any    (pend_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rdata(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we && waddr == a) return wdata;
        return mreg[a];
    endfunction

    function automatic logic exp_rbusy(input logic [AW-1:0] a);
        return (a != 0) && mpend[a] && !(we && waddr == a);
    endfunction

    function automatic logic exp_pend_any();
        for (int r = 0; r < NREG; r++) if (mpend[r]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            mreg[r]  = '0;
            mpend[r] = 1'b0;
        end
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         input logic iv, input logic [AW-1:0] ird, input logic fl);
        we = w; waddr = wa; wdata = wd;
        raddr = {r1, r0};
        issue_valid = iv; issue_rd = ird; flush = fl;
        #1;
    endtask

    task automatic check_model();
        logic [AW-1:0] a;
        for (int i = 0; i < NRD; i++) begin
            a = raddr[i*AW +: AW];
            check($sformatf("rdata%0d@x%0d", i, a), rdata[i*XLEN +: XLEN], exp_rdata(a));
            check($sformatf("rbusy%0d@x%0d", i, a), XLEN'(rbusy[i]), XLEN'(exp_rbusy(a)));
        end
        check("pend_any", XLEN'(pend_any), XLEN'(exp_pend_any()));
    endtask

    // Advance one clock edge and apply the architectural effect of the held inputs
    task automatic tick();
        @(posedge clk);
        if (we && waddr != 0) mreg[waddr] = wdata;
        if (flush) begin
            for (int r = 0; r < NREG; r++) mpend[r] = 1'b0;
        end else begin
            if (we) mpend[waddr] = 1'b0;
            if (issue_valid && issue_rd != 0) mpend[issue_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_cycle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        drive(0, 0, 0, r0, r1, 0, 0, 0);
        check_model();
        tick();
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        drive(0, 0, 0, 5, 0, 0, 0, 0);
        check("reset_rdata0", rdata[31:0], 32'h0);
        check("reset_pend_any", XLEN'(pend_any), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;

        // Write then read back; writes to x0 are dropped
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0); check_model(); tick();
        drive(1, 0, 32'h1234, 5, 0, 0, 0, 0); check_model();
        check("x5_read", rdata[31:0], 32'hDEADBEEF);
        tick();
        drive(0, 0, 0, 0, 5, 0, 0, 0); check_model();
        check("x0_read", rdata[31:0], 32'h0);
        tick();

        // Same-cycle bypass on both ports
        drive(1, 7, 32'hA5A5A5A5, 7, 7, 0, 0, 0); check_model();
        check("bypass0", rdata[31:0], 32'hA5A5A5A5);
        check("bypass1", rdata[63:32], 32'hA5A5A5A5);
        tick();

        // Scoreboard lifecycle on x3
        drive(0, 0, 0, 3, 0, 1, 3, 0); check_model(); tick();
        drive(0, 0, 0, 3, 0, 0, 0, 0);
        check("x3_busy", XLEN'(rbusy[0]), 32'h1);
        check("x3_pend_any", XLEN'(pend_any), 32'h1);
        for (int k = 0; k < 3; k++) idle_cycle(3, 0);
        drive(1, 3, 32'h42, 3, 0, 0, 0, 0); check_model();
        check("x3_wb_unbusy", XLEN'(rbusy[0]), 32'h0);
        check("x3_wb_data", rdata[31:0], 32'h42);
        tick();
        drive(0, 0, 0, 3, 0, 0, 0, 0);
        check("x3_pend_any_clear", XLEN'(pend_any), 32'h0);

        // Set beats clear on the same register
        drive(0, 0, 0, 9, 0, 1, 9, 0); check_model(); tick();
        drive(1, 9, 32'h11, 9, 0, 1, 9, 0); check_model(); tick();
        drive(0, 0, 0, 9, 0, 0, 0, 0); check_model();
        check("x9_still_busy", XLEN'(rbusy[0]), 32'h1);
        check("x9_data", rdata[31:0], 32'h11);

        // Flush beats a same-cycle issue
        drive(0, 0, 0, 4, 6, 1, 4, 0); tick();
        drive(0, 0, 0, 4, 6, 1, 6, 0); tick();
        drive(0, 0, 0, 4, 6, 1, 8, 1); check_model(); tick();
        drive(0, 0, 0, 4, 8, 0, 0, 0); check_model();
        check("flush_pend_any", XLEN'(pend_any), 32'h0);
        check("flush_x8", XLEN'(rbusy[1]), 32'h0);

        // Issue to x0 is never tracked
        drive(0, 0, 0, 0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("x0_issue_pend_any", XLEN'(pend_any), 32'h0);

        // Asynchronous reset between edges
        drive(1, 2, 32'h55, 0, 0, 1, 2, 0); tick();
        drive(0, 0, 0, 2, 0, 0, 0, 0);
        check("x2_before_reset", rdata[31:0], 32'h55);
        check("x2_busy_before_reset", XLEN'(rbusy[0]), 32'h1);
        reset = 1'b1;
        #1;
        model_reset();
        check("x2_async_rdata", rdata[31:0], 32'h0);
        check("x2_async_rbusy", XLEN'(rbusy[0]), 32'h0);
        check("async_pend_any", XLEN'(pend_any), 32'h0);
        reset = 1'b0;
        #1;
        tick();

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom,
                  AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                  ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 3) == 0) raddr[AW-1:0] = waddr;
            if ($urandom_range(0, 3) == 0) raddr[2*AW-1:AW] = issue_rd;
            #1;
            check_model();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the core's integer register file for the pipelined RISC-V datapath.
- Provides NUM_RD combinational read ports, one write port with same-cycle write-to-read bypass, and a per-register scoreboard of pending writes.
- Decode reads operands and busy status here. Decode also marks the destination register at issue. Writeback clears the pending mark. Flush clears all pending marks on a pipeline squash.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers. Must be a power of two and at least 2.
- NUM_RD, 2, number of independent read ports (at least 1).
- AW, $clog2(NREG), derived localparam for address width. Not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  writeback write enable.
- waddr  in  AW  writeback destination register.
- wdata  in  XLEN  writeback data.
- raddr  in  NUM_RD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NUM_RD*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].
- rbusy  out  NUM_RD  port i operand still awaiting a writeback (decode stalls on this).
- issue_valid  in  1  an instruction with a destination register issues this cycle.
- issue_rd  in  AW  destination register of the issuing instruction.
- flush  in  1  squash: clear every pending mark.
- pend_any  out  1  at least one register is pending.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- On reset assertion, immediately and without waiting for a clock edge:
  - all NREG registers become 0;
  - all pending bits become 0;
  - consequently all rdata read 0, rbusy is all 0, and pend_any is 0.
- Register 0:
  - always reads 0;
  - writes to it are ignored;
  - issue_rd=0 never sets a pending bit;
  - rbusy for an address of 0 is always 0.
- Write: at the rising edge, if we and waddr!=0, then reg[waddr] <= wdata. Visible to a normal read from the next cycle.
- Read (combinational, zero latency), for each port i:
  - if raddr_i==0, rdata_i=0;
  - else if we and waddr==raddr_i, rdata_i=wdata (bypass; write-then-read in the same cycle);
  - else rdata_i=reg[raddr_i].
  - Multiple ports may use the same address and return identical data.
- Scoreboard pending[NREG], updated at the rising edge. Per register r, highest priority first:
  - 1. flush: pending[r] <= 0 for all r.
  - 2. issue_valid and issue_rd==r and r!=0: pending[r] <= 1. Set wins over a same-cycle clear of the same register, because the new producer supersedes the old one.
  - 3. we and waddr==r: pending[r] <= 0.
  - 4. otherwise hold.
  - A flush and an issue in the same cycle: flush wins and the issue is dropped, because the issuing instruction is squashed.
  - A writeback to a register that is not pending still writes data, and the pending bit stays 0.
- rbusy_i = pending[raddr_i] AND NOT(we and waddr==raddr_i) AND raddr_i!=0. A same-cycle writeback therefore un-busies the port via the bypass.
- pend_any = OR of all pending bits (registered state only).
- Reset asserted mid-operation:
  - overrides everything, including we, issue_valid and flush in that cycle;
  - after deassertion, the first rising edge behaves normally.
- No X propagation: rdata is defined for all addresses because NREG == 2**AW.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN;
  - REG_ZERO = '0 address constant;
  - a typedef for the register address and data sized from the defaults.
- Sub-module regfile_scoreboard holds:
  - the pending vector, the flush/issue/clear priority logic, the rbusy generation and pend_any.
  - Parameters: NREG, NUM_RD.
- Top-level regfile_sb holds the storage array, the write logic and the bypass muxes.

Test Plan:
- Reset then read: assert reset, then write reg5=0xDEADBEEF and read port0 addr 5 on the next cycle -> 0xDEADBEEF. Reading addr 0 after writing 0x1234 to x0 -> 0.
- Bypass: in one cycle drive we=1, waddr=7, wdata=0xA5A5A5A5, raddr0=7, raddr1=7 -> both rdata=0xA5A5A5A5 in that cycle, before the edge.
- Scoreboard lifecycle:
  - issue x3 at cycle N -> rbusy0=1 for raddr0=3 from N+1, pend_any=1;
  - writeback x3=0x42 at cycle N+4 -> rbusy0=0 with rdata0=0x42 during N+4, pend_any=0 at N+5.
- Simultaneous set and clear: x9 pending; in one cycle, issue x9 and write back x9=0x11 -> after the edge pending[9]=1 and rdata=0x11.
- Flush priority: x4 and x6 pending; flush=1 with issue_valid=1, issue_rd=8 -> after the edge pending is all 0 and pend_any=0.
- Async reset mid-stream: x2=0x55 and x2 pending; assert reset between clock edges -> rdata for x2 is 0 and rbusy is 0 immediately, with no clock edge.
